// File: rtl/jtag_idcode_reader.sv
// JTAG host initiator: walks the target TAP to Shift-DR, captures the 32-bit IDCODE
// and returns to Run-Test/Idle. Optional comparator enabled by `define IDCODE_CHECK_EN.
module jtag_idcode_reader #(
    parameter int          TCK_DIV     = 2,
    parameter logic [31:0] EXPECTED_ID = 32'h1234_5679
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] idcode,
    output logic        lsb_err,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo
`ifdef IDCODE_CHECK_EN
    ,
    output logic        id_match
`endif
);

    localparam int DIV_W = $clog2(TCK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        TLR,
        TO_SHIFT,
        SHIFT,
        EXIT,
        FINISH
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       edge_cnt;
    logic [31:0]      shift_reg;
    logic [5:0]       next_edge;

    assign next_edge = edge_cnt + 6'd1;
    assign tdi       = 1'b0;

    // TAP region that owns a given TCK rising edge (1..43).
    function automatic state_t state_for_edge(input logic [5:0] e);
        if (e <= 6'd5)       return TLR;
        else if (e <= 6'd9)  return TO_SHIFT;
        else if (e <= 6'd40) return SHIFT;
        else if (e <= 6'd42) return EXIT;
        else                 return FINISH;
    endfunction

    function automatic logic tms_for_edge(input logic [5:0] e);
        return (e <= 6'd5) || (e == 6'd7) || (e == 6'd41) || (e == 6'd42);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            edge_cnt  <= '0;
            shift_reg <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            idcode    <= '0;
            lsb_err   <= 1'b0;
            tck       <= 1'b0;
            tms       <= 1'b1;
`ifdef IDCODE_CHECK_EN
            id_match  <= 1'b0;
`endif
        end else begin
            // NOTE: default-low here makes done a single-cycle pulse without extra state.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= TLR;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                        tck      <= 1'b0;
                        tms      <= 1'b1;
                    end
                end
                default: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!tck) begin
                            // Rising TCK: the target's sampling edge; TDO bits for edges 10..41.
                            tck      <= 1'b1;
                            edge_cnt <= next_edge;
                            if (next_edge >= 6'd10 && next_edge <= 6'd41)
                                shift_reg <= {tdo, shift_reg[31:1]};
                        end else begin
                            tck <= 1'b0;
                            if (state == FINISH) begin
                                state   <= IDLE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                tms     <= 1'b1;
                                idcode  <= shift_reg;
                                lsb_err <= ~shift_reg[0];
`ifdef IDCODE_CHECK_EN
                                id_match <= (shift_reg == EXPECTED_ID);
`endif
                            end else begin
                                state <= state_for_edge(next_edge);
                                tms   <= tms_for_edge(next_edge);
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
